// File: rtl/coin_key_frontend_pkg.sv
// coin_key_frontend_pkg: key indices, coin encodings and default 50 MHz timing shared by the front end
package coin_key_frontend_pkg;
   localparam int KEY_C05  = 0;
   localparam int KEY_C10  = 1;
   localparam int KEY_CAN  = 2;
   localparam int KEY_TAKE = 3;
   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_05   = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;
   localparam int DEF_DEBOUNCE_CYCLES = 2500000;
   localparam int DEF_GAP_CYCLES      = 25000000;
   localparam int DEF_CNT_W           = 25;
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction
endpackage

// File: rtl/coin_key_frontend_key_debounce_pulse.sv
// key_debounce_pulse: two-flop synchroniser, debounce counter, stable level and press pulse for one active-low key
module key_debounce_pulse #(
   parameter int DEBOUNCE_CYCLES = 2500000,
   parameter int CNT_W           = 25
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_n_i,
   output logic stable_o,
   output logic press_o
);
   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d, press_q, press_d, mismatch, done;
   always_comb begin
      mismatch = sync_q[1] != stable_q;
      done     = mismatch && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
      cnt_d    = (mismatch && !done) ? cnt_q + CNT_W'(1) : '0;
      stable_d = done ? sync_q[1] : stable_q;
      // pulse is registered alongside the stable level so it costs no extra cycle
      press_d  = stable_q & ~stable_d;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q   <= 2'b11;
         cnt_q    <= '0;
         stable_q <= 1'b1;
         press_q  <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], key_n_i};
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         press_q  <= press_d;
      end
   end
   assign stable_o = stable_q;
   assign press_o  = press_q;
endmodule

// File: rtl/coin_key_frontend.sv
// coin_key_frontend: debounces the four vending buttons, arbitrates coin presses and counts accepted coins
module coin_key_frontend
   import coin_key_frontend_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_n,
   input  logic       coin_en,
   output logic [1:0] coin_val,
   output logic       coin_rej,
   output logic       cancel_n,
   output logic       take_n,
   output logic       cancel_pls,
   output logic [7:0] coin_cnt
);
   logic [3:0]       stable, press;
   logic [1:0]       coin_val_q, coin_val_d;
   logic             coin_rej_q, coin_rej_d, cancel_pls_q, coin_any, acc;
   logic [CNT_W-1:0] gap_q, gap_d;
   logic [7:0]       cnt_q, cnt_d;
   for (genvar i = 0; i < 4; i++) begin : g_key
      key_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key (
         .clk_i(clk), .rst_ni(rst), .key_n_i(key_n[i]), .stable_o(stable[i]), .press_o(press[i])
      );
   end
   // a single reject covers cancel collision, double coin, disabled coins and hold-off alike
   always_comb begin
      coin_any   = press[KEY_C05] | press[KEY_C10];
      coin_rej_d = coin_any & (press[KEY_CAN] | (press[KEY_C05] & press[KEY_C10]) | ~coin_en | (gap_q != '0));
      acc        = coin_any & ~coin_rej_d;
      coin_val_d = acc ? (press[KEY_C05] ? COIN_05 : COIN_10) : COIN_NONE;
      gap_d      = acc ? CNT_W'(GAP_CYCLES - 1) : (gap_q != '0) ? gap_q - CNT_W'(1) : gap_q;
      cnt_d      = press[KEY_CAN] ? 8'd0 : acc ? sat_inc(cnt_q) : cnt_q;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         coin_val_q   <= COIN_NONE;
         coin_rej_q   <= 1'b0;
         cancel_pls_q <= 1'b0;
         gap_q        <= '0;
         cnt_q        <= '0;
      end else begin
         coin_val_q   <= coin_val_d;
         coin_rej_q   <= coin_rej_d;
         cancel_pls_q <= press[KEY_CAN];
         gap_q        <= gap_d;
         cnt_q        <= cnt_d;
      end
   end
   assign coin_val   = coin_val_q;
   assign coin_rej   = coin_rej_q;
   assign cancel_pls = cancel_pls_q;
   assign coin_cnt   = cnt_q;
   assign cancel_n   = stable[KEY_CAN];
   assign take_n     = stable[KEY_TAKE];
endmodule

// File: tb/tb_coin_key_frontend.sv
// tb_coin_key_frontend: table-driven and sequence checks of the coin/key front end with short debounce and gap
module tb_coin_key_frontend;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key_n = 4'b1111;
   logic       coin_en = 1'b1;
   logic [1:0] coin_val;
   logic       coin_rej, cancel_n, take_n, cancel_pls;
   logic [7:0] coin_cnt;

   always #5 clk = ~clk;

   coin_key_frontend #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(10), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .key_n(key_n), .coin_en(coin_en), .coin_val(coin_val),
      .coin_rej(coin_rej), .cancel_n(cancel_n), .take_n(take_n), .cancel_pls(cancel_pls), .coin_cnt(coin_cnt)
   );

   typedef struct {
      logic [3:0] kn;
      logic       en;
      logic [1:0] val;
      logic       rej, cann, taken, cpls;
      logic [7:0] cnt;
   } vec_t;

   vec_t       tbl[48];
   int         pass_cnt = 0;
   int         total = 0;
   int         idx = 0;
   int         pls_total = 0;
   logic [1:0] rv[64];
   logic       rr[64], rc[64], rp[64];
   logic [7:0] rn[64];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic run(input logic [3:0] kn, input int n);
      for (int i = 0; i < n; i++) begin
         key_n = kn;
         @(posedge clk);
         #1;
         if (idx < 64) begin
            rv[idx] = coin_val;
            rr[idx] = coin_rej;
            rc[idx] = cancel_n;
            rp[idx] = cancel_pls;
            rn[idx] = coin_cnt;
         end
         idx++;
         if (coin_val == 2'b01) pls_total++;
      end
   endtask

   function automatic int npulse(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (rv[i] != 2'b00) n++;
      return n;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_val"}, 32'(coin_val), 32'd0);
      chk({tag, "_rej"}, 32'(coin_rej), 32'd0);
      chk({tag, "_cancel_n"}, 32'(cancel_n), 32'd1);
      chk({tag, "_take_n"}, 32'(take_n), 32'd1);
      chk({tag, "_cpls"}, 32'(cancel_pls), 32'd0);
      chk({tag, "_cnt"}, 32'(coin_cnt), 32'd0);
   endtask

   initial begin
      for (int k = 0; k < 28; k++)
         tbl[k] = '{(k < 20) ? 4'b1110 : 4'b1111, 1'b1, (k == 6) ? 2'b01 : 2'b00,
                    1'b0, 1'b1, 1'b1, 1'b0, (k >= 6) ? 8'd1 : 8'd0};
      for (int k = 0; k < 20; k++)
         tbl[28 + k] = '{(k < 12) ? 4'b0111 : 4'b1111, 1'b1, 2'b00,
                         1'b0, 1'b1, (k >= 5 && k < 17) ? 1'b0 : 1'b1, 1'b0, 8'd1};
      #2 rst = 1'b0;
      #1 chk_reset("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      for (int k = 0; k < 48; k++) begin
         key_n   = tbl[k].kn;
         coin_en = tbl[k].en;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d", k), 32'({coin_val, coin_rej, cancel_n, take_n, cancel_pls, coin_cnt}),
             32'({tbl[k].val, tbl[k].rej, tbl[k].cann, tbl[k].taken, tbl[k].cpls, tbl[k].cnt}));
      end

      // bouncing 1.0 key, then a clean hold
      idx = 0;
      repeat (3) begin
         run(4'b1101, 2);
         run(4'b1111, 2);
      end
      run(4'b1101, 10);
      chk("bounce_quiet", 32'(npulse(0, 17)), 32'd0);
      chk("bounce_val", 32'(rv[18]), 32'd2);
      chk("bounce_cnt", 32'(rn[18]), 32'd2);
      chk("bounce_single", 32'(npulse(19, 21)), 32'd0);
      run(4'b1111, 10);

      // both coins together
      idx = 0;
      run(4'b1100, 10);
      chk("dual_val", 32'(rv[6]), 32'd0);
      chk("dual_rej", 32'(rr[6]), 32'd1);
      chk("dual_rej_once", 32'(rr[7]), 32'd0);
      chk("dual_cnt", 32'(rn[9]), 32'd2);
      run(4'b1111, 10);

      // second 0.5 press inside the hold-off window, third after it
      idx = 0;
      run(4'b1110, 5);
      run(4'b1111, 4);
      run(4'b1110, 8);
      chk("gap_first_val", 32'(rv[6]), 32'd1);
      chk("gap_first_cnt", 32'(rn[6]), 32'd3);
      chk("gap_rej", 32'(rr[15]), 32'd1);
      chk("gap_rej_val", 32'(rv[15]), 32'd0);
      chk("gap_no_val", 32'(npulse(7, 16)), 32'd0);
      chk("gap_cnt_hold", 32'(rn[16]), 32'd3);
      run(4'b1111, 20);
      idx = 0;
      run(4'b1110, 8);
      chk("gap_third_val", 32'(rv[6]), 32'd1);
      chk("gap_third_cnt", 32'(rn[6]), 32'd4);
      run(4'b1111, 10);

      // coins disabled
      coin_en = 1'b0;
      idx = 0;
      run(4'b1101, 8);
      chk("dis_rej", 32'(rr[6]), 32'd1);
      chk("dis_val", 32'(rv[6]), 32'd0);
      chk("dis_cnt", 32'(rn[7]), 32'd4);
      run(4'b1111, 10);
      coin_en = 1'b1;

      // cancel coincident with a 1.0 press
      idx = 0;
      run(4'b1001, 10);
      chk("can_rej", 32'(rr[6]), 32'd1);
      chk("can_pls", 32'(rp[6]), 32'd1);
      chk("can_pls_once", 32'(rp[7]), 32'd0);
      chk("can_val", 32'(rv[6]), 32'd0);
      chk("can_n_before", 32'(rc[4]), 32'd1);
      chk("can_n_low", 32'(rc[5]), 32'd0);
      chk("can_n_held", 32'(rc[9]), 32'd0);
      chk("can_cnt", 32'(rn[7]), 32'd0);
      run(4'b1111, 10);

      // two accepted coins so the reset visibly clears the counter
      repeat (2) begin
         run(4'b1110, 6);
         run(4'b1111, 14);
      end
      chk("pre_rst_cnt", 32'(coin_cnt), 32'd2);

      // reset mid-debounce with the key held through release
      idx = 0;
      run(4'b1110, 4);
      rst = 1'b0;
      #1 chk_reset("mid_rst");
      @(posedge clk);
      #1 rst = 1'b1;
      idx = 0;
      run(4'b1110, 10);
      chk("rst_val", 32'(rv[6]), 32'd1);
      chk("rst_single", 32'(npulse(0, 9)), 32'd1);
      chk("rst_cnt", 32'(rn[6]), 32'd1);
      run(4'b1111, 10);

      // saturation of the accepted-coin counter
      pls_total = 0;
      for (int it = 0; it < 260; it++) begin
         idx = 0;
         run(4'b1110, 6);
         run(4'b1111, 14);
         if (it == 252) chk("sat_254", 32'(coin_cnt), 32'd254);
         if (it == 253) chk("sat_255", 32'(coin_cnt), 32'd255);
      end
      chk("sat_hold", 32'(coin_cnt), 32'd255);
      chk("sat_pulses", 32'(pls_total), 32'd260);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
